// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 3-stage signed add/multiply/multiply-accumulate pipeline with optional saturation
module dsp_mac_pipe #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 48,
    parameter int SAT   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic [1:0]              mode,
    input  logic                    acc_clr,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] p,
    output logic                    ovf
);
    localparam int PW = A_W + B_W;
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_MAC = 2'b10;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    if (ACC_W < PW + 1) begin : g_width_check
        $error("dsp_mac_pipe: ACC_W must be at least A_W+B_W+1");
    end

    logic                    v1, v2, clr1, clr2, mac2;
    logic [1:0]              mode1;
    logic signed [A_W-1:0]   a1;
    logic signed [B_W-1:0]   b1;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] m, m_next, acc, acc_next;
    logic signed [ACC_W:0]   s;
    logic                    ovf_hit;

    // Stage 1: capture operands and control; data regs hold across bubbles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1    <= 1'b0;
            a1    <= '0;
            b1    <= '0;
            mode1 <= '0;
            clr1  <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                a1    <= a;
                b1    <= b;
                mode1 <= mode;
                clr1  <= acc_clr;
            end
        end
    end

    // Stage 2 datapath: the product stays at A_W+B_W so it maps onto a DSP multiplier
    always_comb begin
        prod   = {{B_W{a1[A_W-1]}}, a1} * {{A_W{b1[B_W-1]}}, b1};
        m_next = (mode1 == MODE_ADD)
               ? {{(ACC_W-A_W){a1[A_W-1]}}, a1} + {{(ACC_W-B_W){b1[B_W-1]}}, b1}
               : {{(ACC_W-PW){prod[PW-1]}}, prod};
    end

    // Stage 2: register add/product result and forward MAC control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2   <= 1'b0;
            m    <= '0;
            mac2 <= 1'b0;
            clr2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                m    <= m_next;
                mac2 <= (mode1 == MODE_MAC);
                clr2 <= clr1;
            end
        end
    end

    // Accumulate one bit wider so a sign disagreement in the top two bits flags overflow
    always_comb begin
        s        = {acc[ACC_W-1], acc} + {m[ACC_W-1], m};
        ovf_hit  = s[ACC_W] ^ s[ACC_W-1];
        acc_next = (!ovf_hit || SAT == 0) ? s[ACC_W-1:0] : (s[ACC_W] ? ACC_MIN : ACC_MAX);
    end

    // Stage 3: result register, accumulator feedback and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            p         <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                if (!mac2) begin
                    p <= m;
                end else if (clr2) begin
                    acc <= m;
                    p   <= m;
                    ovf <= 1'b0;
                end else begin
                    acc <= acc_next;
                    p   <= acc_next;
                    if (ovf_hit) ovf <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed vectors against 48-bit wrap, 17-bit saturating and 17-bit wrapping units
module tb_dsp_mac_pipe;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, acc_clr = 1'b0;
    logic signed [7:0] a = '0, b = '0;
    logic [1:0] mode = '0;
    logic vd, vs, vw, od, os, ow;
    logic signed [47:0] pd;
    logic signed [16:0] ps, pw;
    int checks = 0, errors = 0;

    typedef struct {
        bit rst; bit v; int a; int b; int mode; bit clr; bit ev;
        longint pd; longint ps; longint pw; bit od; bit os; bit ow;
    } vec_t;
    vec_t q[$];

    always #5 clk = ~clk;

    dsp_mac_pipe #(.A_W(8), .B_W(8), .ACC_W(48), .SAT(0)) u_d (.clk(clk), .reset(reset), .in_valid(in_valid),
        .a(a), .b(b), .mode(mode), .acc_clr(acc_clr), .out_valid(vd), .p(pd), .ovf(od));
    dsp_mac_pipe #(.A_W(8), .B_W(8), .ACC_W(17), .SAT(1)) u_s (.clk(clk), .reset(reset), .in_valid(in_valid),
        .a(a), .b(b), .mode(mode), .acc_clr(acc_clr), .out_valid(vs), .p(ps), .ovf(os));
    dsp_mac_pipe #(.A_W(8), .B_W(8), .ACC_W(17), .SAT(0)) u_w (.clk(clk), .reset(reset), .in_valid(in_valid),
        .a(a), .b(b), .mode(mode), .acc_clr(acc_clr), .out_valid(vw), .p(pw), .ovf(ow));

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic add(input bit rst, input bit v, input int aa, input int bb, input int md, input bit clr,
                       input bit ev, input longint xd, input longint xs, input longint xw,
                       input bit yd, input bit ys, input bit yw);
        vec_t t;
        t = '{rst, v, aa, bb, md, clr, ev, xd, xs, xw, yd, ys, yw};
        q.push_back(t);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vd"}, vd, 0); chk({tag, "_vs"}, vs, 0); chk({tag, "_vw"}, vw, 0);
        chk({tag, "_pd"}, pd, 0); chk({tag, "_ps"}, ps, 0); chk({tag, "_pw"}, pw, 0);
        chk({tag, "_od"}, od, 0); chk({tag, "_os"}, os, 0); chk({tag, "_ow"}, ow, 0);
    endtask

    initial begin
        vec_t t, e;
        //  rst v  a     b    md clr ev  pd      ps      pw     od os ow
        add(0, 1, -128, -128, 1, 0, 1, 16384,  16384,  16384,  0, 0, 0);
        add(0, 1,  127, -128, 1, 0, 1, -16256, -16256, -16256, 0, 0, 0);
        add(0, 1,    0,    5, 1, 0, 1, 0,      0,      0,      0, 0, 0);
        add(0, 1,  127,  127, 0, 0, 1, 254,    254,    254,    0, 0, 0);
        add(0, 1, -128,   -1, 0, 0, 1, -129,   -129,   -129,   0, 0, 0);
        add(0, 1,    3,    4, 2, 1, 1, 12,     12,     12,     0, 0, 0);
        add(0, 1,    5,    6, 2, 0, 1, 42,     42,     42,     0, 0, 0);
        add(0, 0,   99,   99, 2, 1, 0, 0,      0,      0,      0, 0, 0);
        add(0, 1,   -2,    7, 2, 0, 1, 28,     28,     28,     0, 0, 0);
        add(0, 1,    1,    1, 1, 0, 1, 1,      1,      1,      0, 0, 0);
        add(0, 1,    2,    3, 3, 1, 1, 6,      6,      6,      0, 0, 0);
        add(0, 1,    1,    2, 2, 0, 1, 30,     30,     30,     0, 0, 0);
        add(0, 1,  127,  127, 2, 1, 1, 16129,  16129,  16129,  0, 0, 0);
        add(0, 1,  127,  127, 2, 0, 1, 32258,  32258,  32258,  0, 0, 0);
        add(0, 1,  127,  127, 2, 0, 1, 48387,  48387,  48387,  0, 0, 0);
        add(0, 1,  127,  127, 2, 0, 1, 64516,  64516,  64516,  0, 0, 0);
        add(0, 1,  127,  127, 2, 0, 1, 80645,  65535,  -50427, 0, 1, 1);
        add(0, 1,  127,  127, 2, 0, 1, 96774,  65535,  -34298, 0, 1, 1);
        add(0, 1,    1,    1, 0, 0, 1, 2,      2,      2,      0, 1, 1);
        add(0, 1, -128,  127, 2, 0, 1, 80518,  49279,  -50554, 0, 1, 1);
        add(0, 1, -128,  127, 2, 0, 1, 64262,  33023,  64262,  0, 1, 1);
        add(0, 1, -128,  127, 2, 0, 1, 48006,  16767,  48006,  0, 1, 1);
        add(0, 1, -128,  127, 2, 0, 1, 31750,  511,    31750,  0, 1, 1);
        add(0, 1, -128,  127, 2, 0, 1, 15494,  -15745, 15494,  0, 1, 1);
        add(0, 1, -128,  127, 2, 0, 1, -762,   -32001, -762,   0, 1, 1);
        add(0, 1, -128,  127, 2, 0, 1, -17018, -48257, -17018, 0, 1, 1);
        add(0, 1, -128,  127, 2, 0, 1, -33274, -64513, -33274, 0, 1, 1);
        add(0, 1, -128,  127, 2, 0, 1, -49530, -65536, -49530, 0, 1, 1);
        add(0, 1,    2,    2, 2, 1, 1, 4,      4,      4,      0, 0, 0);
        add(0, 1,    1,    1, 2, 1, 0, 0,      0,      0,      0, 0, 0);
        add(0, 1,    1,    1, 2, 0, 0, 0,      0,      0,      0, 0, 0);
        add(1, 1,    1,    1, 2, 0, 0, 0,      0,      0,      0, 0, 0);
        add(0, 1,    2,    2, 2, 1, 1, 4,      4,      4,      0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_zero($sformatf("rst%0d", i));
            in_valid = ~in_valid; mode = 2'b10; acc_clr = 1'b1; a = 8'sd5; b = 8'sd5;
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_zero($sformatf("idle%0d", i));
        end

        for (int k = 0; k < q.size() + 3; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                e = q[k-3];
                chk($sformatf("vd%0d", k-3), vd, e.ev);
                chk($sformatf("vs%0d", k-3), vs, e.ev);
                chk($sformatf("vw%0d", k-3), vw, e.ev);
                if (e.ev) begin
                    chk($sformatf("pd%0d", k-3), pd, e.pd);
                    chk($sformatf("ps%0d", k-3), ps, e.ps);
                    chk($sformatf("pw%0d", k-3), pw, e.pw);
                    chk($sformatf("od%0d", k-3), od, e.od);
                    chk($sformatf("os%0d", k-3), os, e.os);
                    chk($sformatf("ow%0d", k-3), ow, e.ow);
                end
            end
            if (k < q.size()) begin
                t = q[k];
                reset = t.rst; in_valid = t.v; a = 8'(t.a); b = 8'(t.b);
                mode = 2'(t.mode); acc_clr = t.clr;
                if (t.rst) begin
                    #1;
                    chk_zero("midrst");
                end
            end else begin
                reset = 1'b0; in_valid = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
